// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
//
// Far-end responder for the CPU byte bus. It serves byte reads and writes from
// an internal RAM, and decodes an I/O window at 0x30000-0x3FFFF.
//
// Every bus cycle is a transfer. mem_wr=1 is a write; mem_wr=0 is a read. A
// read's data appears on mem_dout one edge later and holds until the next read
// completes.
//
// I/O map (offset within the window):
//   0x0000  read : pop RX head (0x00 when empty)
//           write: push non-zero byte into TX (0x00 ignored)
//   0x0004  read : counter byte 0, and latch full counter into the snapshot
//           write: set program_done and push 0x00 into TX
//   0x0005-0x0007 read: snapshot bytes 1-3
//   others  read 0x00, writes ignored
//
// Ports:
//   clk_in, rst_in          clock, async active-low reset
//   mem_a/mem_din/mem_wr    CPU bus request; mem_dout is the registered read data
//   io_buffer_full          TX occupancy >= depth-2 (the CPU stalls on it)
//   rx_data/rx_valid/rx_ready  host -> RX FIFO; push when rx_valid && rx_ready
//   tx_data/tx_valid/tx_ready  TX FIFO -> host; pop when tx_valid && tx_ready
//   program_done, tx_overflow  sticky status flags
//
// Handshake: a transfer happens on an edge where valid && ready are both high.
// rx_ready depends only on RX occupancy, not on a same-cycle CPU pop.
// -----------------------------------------------------------------------------
module mem_io_responder #(
  parameter int RAM_ADDR_W      = 17,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        mem_wr,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic is_io;
  logic sel_uart;
  logic sel_cnt0;
  logic rd_en;
  logic wr_en;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic unused_addr;

  assign is_io       = (mem_a[17:16] == 2'b11);
  assign sel_uart    = is_io && (mem_a[15:0] == 16'h0000);
  assign sel_cnt0    = is_io && (mem_a[15:0] == 16'h0004);
  assign rd_en       = !mem_wr;
  assign wr_en       = mem_wr;
  assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
  assign unused_addr = ^mem_a[31:18];

  // ---------------------------------------------------------------------------
  // Byte RAM: write at the edge, read combinationally into the mem_dout flop.
  // Contents survive reset.
  // ---------------------------------------------------------------------------
  logic [7:0] ram_mem [0:(1<<RAM_ADDR_W)-1];

  always_ff @(posedge clk_in) begin
    if (wr_en && !is_io) ram_mem[ram_idx] <= mem_din;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_dout_q,     mem_dout_d;
  logic [31:0] cnt_q,          cnt_d;
  logic [31:0] snap_q,         snap_d;
  logic        program_done_q, program_done_d;
  logic        tx_overflow_q,  tx_overflow_d;

  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_cnt_q,    rx_cnt_d;
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q,    tx_cnt_d;

  logic [7:0] rx_mem [0:DEPTH-1];
  logic [7:0] tx_mem [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_push_req, tx_push, tx_pop;
  logic [7:0] tx_push_data;

  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd_en && sel_uart && !rx_empty;

  assign tx_full      = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty     = (tx_cnt_q == '0);
  assign tx_pop       = !tx_empty && tx_ready;
  // The stop write pushes 0x00 past the zero filter.
  assign tx_push_req  = wr_en && ((sel_uart && (mem_din != 8'h00)) || sel_cnt0);
  assign tx_push_data = sel_cnt0 ? 8'h00 : mem_din;
  // A same-edge pop frees the slot the push lands in, so full is not a block.
  assign tx_push      = tx_push_req && (!tx_full || tx_pop);

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
  end

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (!is_io) begin
      rd_data = ram_mem[ram_idx];
    end else begin
      case (mem_a[15:0])
        16'h0000: rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
        16'h0004: rd_data = cnt_q[7:0];
        16'h0005: rd_data = snap_q[15:8];
        16'h0006: rd_data = snap_q[23:16];
        16'h0007: rd_data = snap_q[31:24];
        default:  rd_data = 8'h00;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_dout_d     = rd_en ? rd_data : mem_dout_q;
    // Counter freezes from the edge after program_done is set.
    cnt_d          = program_done_q ? cnt_q : cnt_q + 32'd1;
    snap_d         = (rd_en && sel_cnt0) ? cnt_q : snap_q;
    program_done_d = program_done_q || (wr_en && sel_cnt0);
    tx_overflow_d  = tx_overflow_q || (tx_push_req && !tx_push);

    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PW'(1) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PW'(1) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_dout_q     <= 8'h00;
      cnt_q          <= 32'd0;
      snap_q         <= 32'd0;
      program_done_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_wr_ptr_q    <= '0;
      rx_rd_ptr_q    <= '0;
      rx_cnt_q       <= '0;
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      tx_cnt_q       <= '0;
    end else begin
      mem_dout_q     <= mem_dout_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      program_done_q <= program_done_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_wr_ptr_q    <= rx_wr_ptr_d;
      rx_rd_ptr_q    <= rx_rd_ptr_d;
      rx_cnt_q       <= rx_cnt_d;
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      tx_cnt_q       <= tx_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_dout       = mem_dout_q;
  assign rx_ready       = !rx_full;
  assign tx_valid       = !tx_empty;
  assign tx_data        = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_q];
  assign io_buffer_full = (tx_cnt_q >= CW'(DEPTH - 2));
  assign program_done   = program_done_q;
  assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0003_0008;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_done;
  logic        tx_overflow;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_din        (mem_din),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .io_buffer_full (io_buffer_full),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  // Reference cycle counter: counts edges since reset release, stops after
  // the edge carrying a stop write.
  logic [31:0] model_cnt;
  logic        model_stop;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      model_cnt  <= 32'd0;
      model_stop <= 1'b0;
    end else begin
      if (!model_stop) model_cnt <= model_cnt + 32'd1;
      if (mem_wr && mem_a[17:0] == 18'h30004) model_stop <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [7:0] rx_m[$];
  logic [7:0] tx_m[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dout(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, mem_dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'h0, mem_dout}, {24'h0, e});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (drive after negedge, sample at the following negedge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_read(input logic [31:0] addr, input logic [7:0] exp, input string tag);
    mem_a  = addr;
    mem_wr = 1'b0;
    exp_q.push_back(exp);
    step();
    mem_a = IDLE_A;
    check_dout(tag);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [7:0] data);
    mem_a   = addr;
    mem_din = data;
    mem_wr  = 1'b1;
    step();
    mem_a  = IDLE_A;
    mem_wr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_dout"},     {24'h0, mem_dout}, 32'h0);
    check({pfx, "_rx_ready"},     {31'h0, rx_ready}, 32'h1);
    check({pfx, "_tx_valid"},     {31'h0, tx_valid}, 32'h0);
    check({pfx, "_tx_data"},      {24'h0, tx_data}, 32'h0);
    check({pfx, "_buf_full"},     {31'h0, io_buffer_full}, 32'h0);
    check({pfx, "_program_done"}, {31'h0, program_done}, 32'h0);
    check({pfx, "_tx_overflow"},  {31'h0, tx_overflow}, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] snap;
    logic [31:0] frozen;
    logic [7:0]  b;
    int          guard;

    rst_in   = 1'b0;
    mem_a    = IDLE_A;
    mem_din  = 8'h00;
    mem_wr   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    repeat (2) @(negedge clk_in);
    check_reset_outputs("rst");
    rst_in = 1'b1;
    step();

    // RAM write/read, write cycle holds mem_dout, top RAM byte.
    cpu_write(32'h0000_0010, 8'hA5);
    cpu_read(32'h0000_0010, 8'hA5, "ram_rd_10");
    cpu_write(32'h0000_0020, 8'h5A);
    check("wr_holds_dout", {24'h0, mem_dout}, 32'hA5);
    cpu_read(32'h0000_0020, 8'h5A, "ram_rd_20");
    cpu_write(32'h0001_FFFF, 8'h3C);
    cpu_read(32'h0001_FFFF, 8'h3C, "ram_rd_top");
    cpu_read(32'h0000_0010, 8'hA5, "ram_rd_10_again");

    // RX: two bytes then an empty read.
    rx_valid = 1'b1;
    rx_data  = 8'h41; rx_m.push_back(8'h41); step();
    rx_data  = 8'h42; rx_m.push_back(8'h42); step();
    rx_valid = 1'b0;
    cpu_read(32'h0003_0000, rx_m.pop_front(), "rx_pop_41");
    cpu_read(32'h0003_0000, rx_m.pop_front(), "rx_pop_42");
    cpu_read(32'h0003_0000, 8'h00, "rx_pop_empty");

    // RX: fill to full with random bytes.
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_data = b;
      rx_m.push_back(b);
      step();
    end
    rx_valid = 1'b0;
    check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
    // Full with a pop in the same cycle: push is refused.
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    cpu_read(32'h0003_0000, rx_m.pop_front(), "rx_pop_full");
    rx_valid = 1'b0;
    check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
    // Simultaneous push and pop while not full.
    rx_valid = 1'b1;
    rx_data  = 8'hDD;
    b = rx_m.pop_front();
    rx_m.push_back(8'hDD);
    cpu_read(32'h0003_0000, b, "rx_push_pop");
    rx_valid = 1'b0;
    check("rx_ready_still_15", {31'h0, rx_ready}, 32'h1);
    while (rx_m.size() > 0) cpu_read(32'h0003_0000, rx_m.pop_front(), "rx_drain");
    cpu_read(32'h0003_0000, 8'h00, "rx_drain_empty");

    // TX: zero filter and order.
    cpu_write(32'h0003_0000, 8'h48);
    cpu_write(32'h0003_0000, 8'h00);
    cpu_write(32'h0003_0000, 8'h69);
    check("tx_valid_48", {31'h0, tx_valid}, 32'h1);
    check("tx_data_48", {24'h0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    step();
    check("tx_data_69", {24'h0, tx_data}, 32'h69);
    step();
    tx_ready = 1'b0;
    check("tx_empty_valid", {31'h0, tx_valid}, 32'h0);
    check("tx_empty_data", {24'h0, tx_data}, 32'h0);

    // TX: 17 pushes with no host pops.
    for (int i = 1; i <= 17; i++) begin
      b = 8'h80 + 8'(i - 1);
      if (i <= 16) tx_m.push_back(b);
      cpu_write(32'h0003_0000, b);
      check($sformatf("buf_full_push%0d", i), {31'h0, io_buffer_full}, {31'h0, (i >= 14)});
      check($sformatf("overflow_push%0d", i), {31'h0, tx_overflow}, {31'h0, (i >= 17)});
    end
    // Full: push and pop on the same edge both succeed.
    tx_ready = 1'b1;
    void'(tx_m.pop_front());
    tx_m.push_back(8'h77);
    cpu_write(32'h0003_0000, 8'h77);
    tx_ready = 1'b0;
    check("tx_full_pushpop_head", {24'h0, tx_data}, 32'h81);
    check("tx_overflow_sticky", {31'h0, tx_overflow}, 32'h1);
    tx_ready = 1'b1;
    while (tx_m.size() > 0) begin
      check("tx_drain_valid", {31'h0, tx_valid}, 32'h1);
      check("tx_drain_data", {24'h0, tx_data}, {24'h0, tx_m.pop_front()});
      step();
    end
    tx_ready = 1'b0;
    check("tx_drained_valid", {31'h0, tx_valid}, 32'h0);
    check("tx_drained_buf_full", {31'h0, io_buffer_full}, 32'h0);

    // Counter snapshot across a byte-0 rollover.
    guard = 0;
    while (model_cnt[7:0] != 8'hFD && guard < 300) begin
      step();
      guard++;
    end
    check("cnt_align_guard", {31'h0, (guard < 300)}, 32'h1);
    snap = model_cnt;
    cpu_read(32'h0003_0004, snap[7:0], "cnt_b0");
    idle(3);
    cpu_read(32'h0003_0005, snap[15:8], "cnt_b1");
    idle(3);
    cpu_read(32'h0003_0006, snap[23:16], "cnt_b2");
    idle(3);
    cpu_read(32'h0003_0007, snap[31:24], "cnt_b3");
    cpu_read(32'h0003_0010, 8'h00, "io_unmapped");

    // Stop write.
    check("pre_stop_done", {31'h0, program_done}, 32'h0);
    cpu_write(32'h0003_0004, 8'h55);
    check("stop_done", {31'h0, program_done}, 32'h1);
    check("stop_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("stop_tx_data", {24'h0, tx_data}, 32'h00);
    frozen = model_cnt;
    cpu_read(32'h0003_0004, frozen[7:0], "frozen_b0_a");
    idle(5);
    cpu_read(32'h0003_0004, frozen[7:0], "frozen_b0_b");
    cpu_read(32'h0003_0005, frozen[15:8], "frozen_b1");

    // TX half full (stop byte plus 7), then reset with a read outstanding.
    for (int i = 0; i < 7; i++) cpu_write(32'h0003_0000, 8'h11 + 8'(i));
    check("half_full_buf", {31'h0, io_buffer_full}, 32'h0);
    check("half_full_valid", {31'h0, tx_valid}, 32'h1);
    cpu_read(32'h0000_0020, 8'h5A, "pre_reset_rd");
    mem_a  = 32'h0000_0010;
    mem_wr = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk_in);
    check("midrst_hold_dout", {24'h0, mem_dout}, 32'h0);
    rst_in = 1'b1;
    mem_a  = IDLE_A;
    step();
    cpu_read(32'h0000_0010, 8'hA5, "post_rst_ram_10");
    cpu_read(32'h0001_FFFF, 8'h3C, "post_rst_ram_top");
    cpu_read(32'h0003_0000, 8'h00, "post_rst_rx_empty");
    snap = model_cnt;
    cpu_read(32'h0003_0004, snap[7:0], "post_rst_cnt");
    check("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("post_rst_done", {31'h0, program_done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
